// File: rtl/urv_timer_irq_if.sv
// Register-port bundle between a bus master and the timer-compare unit.
// Field names match the unit's register-port signals so traces read directly.
interface urv_timer_irq_if;
    logic [2:0]  addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic        re_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;

    modport master (
        output addr_i,
        output wdata_i,
        output we_i,
        output re_i,
        input  rdata_o,
        input  rvalid_o
    );

    modport slave (
        input  addr_i,
        input  wdata_i,
        input  we_i,
        input  re_i,
        output rdata_o,
        output rvalid_o
    );
endinterface

// File: rtl/urv_timer_irq.sv
// Timer-compare interrupt unit: 64-bit compare against csr_time with one-shot or
// periodic reload, plus a tear-free 64-bit time read over a 32-bit register port.
module urv_timer_irq #(
    parameter logic [63:0] g_reset_cmp = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [63:0]       csr_time_i,
    urv_timer_irq_if.slave    bus,
    output logic              irq_o
);

    localparam logic [2:0] ADDR_TIME_LO = 3'd0;
    localparam logic [2:0] ADDR_TIME_HI = 3'd1;
    localparam logic [2:0] ADDR_CMP_LO  = 3'd2;
    localparam logic [2:0] ADDR_CMP_HI  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD  = 3'd4;
    localparam logic [2:0] ADDR_CTRL    = 3'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        periodic_q, periodic_d;
    logic        pending_q, pending_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] cmp_lo_stage_q, cmp_lo_stage_d;
    logic [31:0] period_q, period_d;
    logic [31:0] time_hi_shadow_q, time_hi_shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic        hit_raw;
    logic        wr_blocks_hit;
    logic        hit;
    logic [31:0] rd_mux;

    always_comb begin
        state_d          = state_q;
        periodic_d       = periodic_q;
        pending_d        = pending_q;
        cmp_d            = cmp_q;
        cmp_lo_stage_d   = cmp_lo_stage_q;
        period_d         = period_q;
        time_hi_shadow_d = time_hi_shadow_q;
        rdata_d          = rdata_q;
        rvalid_d         = bus.re_i;

        hit_raw = (state_q == ST_ARMED) && (csr_time_i >= cmp_q);
        // Writes that change what the compare depends on take precedence over a hit.
        wr_blocks_hit = bus.we_i && ((bus.addr_i == ADDR_CMP_HI) ||
                                     (bus.addr_i == ADDR_PERIOD) ||
                                     (bus.addr_i == ADDR_CTRL));
        hit = hit_raw && !wr_blocks_hit;

        case (state_q)
            ST_IDLE: begin
            end
            ST_ARMED: begin
                if (hit) begin
                    pending_d = 1'b1;
                    if (periodic_q) begin
                        cmp_d = cmp_q + {32'd0, period_q};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_mux = 32'd0;
        case (bus.addr_i)
            ADDR_TIME_LO: rd_mux = csr_time_i[31:0];
            ADDR_TIME_HI: rd_mux = time_hi_shadow_q;
            ADDR_CMP_LO:  rd_mux = cmp_q[31:0];
            ADDR_CMP_HI:  rd_mux = cmp_q[63:32];
            ADDR_PERIOD:  rd_mux = period_q;
            ADDR_CTRL:    rd_mux = {29'd0, pending_q, periodic_q, (state_q == ST_ARMED)};
            default:      rd_mux = 32'd0;
        endcase

        if (bus.re_i) begin
            rdata_d = rd_mux;
            if (bus.addr_i == ADDR_TIME_LO) begin
                time_hi_shadow_d = csr_time_i[63:32];
            end
        end

        if (bus.we_i) begin
            case (bus.addr_i)
                ADDR_CMP_LO: cmp_lo_stage_d = bus.wdata_i;
                ADDR_CMP_HI: begin
                    cmp_d     = {bus.wdata_i, cmp_lo_stage_q};
                    pending_d = 1'b0;
                end
                ADDR_PERIOD: period_d = bus.wdata_i;
                ADDR_CTRL: begin
                    state_d    = state_t'(bus.wdata_i[0]);
                    periodic_d = bus.wdata_i[1];
                    // A simultaneous match keeps pending set against the W1C.
                    if (bus.wdata_i[2]) begin
                        pending_d = hit_raw;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= ST_IDLE;
            periodic_q       <= 1'b0;
            pending_q        <= 1'b0;
            cmp_q            <= g_reset_cmp;
            cmp_lo_stage_q   <= 32'd0;
            period_q         <= 32'd0;
            time_hi_shadow_q <= 32'd0;
            rdata_q          <= 32'd0;
            rvalid_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            periodic_q       <= periodic_d;
            pending_q        <= pending_d;
            cmp_q            <= cmp_d;
            cmp_lo_stage_q   <= cmp_lo_stage_d;
            period_q         <= period_d;
            time_hi_shadow_q <= time_hi_shadow_d;
            rdata_q          <= rdata_d;
            rvalid_q         <= rvalid_d;
        end
    end

    assign bus.rdata_o  = rdata_q;
    assign bus.rvalid_o = rvalid_q;
    assign irq_o        = pending_q;

endmodule

// File: tb/tb_urv_timer_irq.sv
// Directed bench for urv_timer_irq: stimulus on the falling edge, checks after it,
// expected values hand-computed per scenario.
module tb_urv_timer_irq;

    logic        clk;
    logic        rst_n;
    logic [63:0] csr_time;
    logic        irq;

    int n_cmp;
    int n_bad;

    urv_timer_irq_if bus ();

    urv_timer_irq dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .csr_time_i (csr_time),
        .bus        (bus),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.we_i    = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        tick();
        bus.we_i    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.re_i   = 1'b1;
        bus.addr_i = a;
        tick();
        bus.re_i   = 1'b0;
        check_eq({tag, ".rvalid"}, {63'd0, bus.rvalid_o}, 64'd1);
        check_eq(tag, {32'd0, bus.rdata_o}, {32'd0, exp});
    endtask

    // Steps time upward one per cycle until irq is seen; all-ones means it never fired.
    task automatic ramp(input logic [63:0] start, input int limit, output logic [63:0] hit_t);
        logic found;
        found = 1'b0;
        hit_t = '1;
        for (int i = 0; i < limit && !found; i++) begin
            csr_time = start + 64'(i);
            tick();
            if (irq) begin
                found = 1'b1;
                hit_t = start + 64'(i);
            end
        end
    endtask

    logic [63:0] hit_t;
    logic [63:0] exp_hit;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        csr_time = 64'd0;
        bus.we_i = 1'b0;
        bus.re_i = 1'b0;
        bus.addr_i = 3'd0;
        bus.wdata_i = 32'd0;

        // Reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            bus.we_i    = $urandom_range(0, 1) == 1;
            bus.re_i    = $urandom_range(0, 1) == 1;
            bus.addr_i  = 3'($urandom_range(0, 7));
            bus.wdata_i = $urandom;
            csr_time    = {$urandom, $urandom};
            tick();
        end
        bus.we_i = 1'b0;
        bus.re_i = 1'b0;
        csr_time = 64'd0;
        check_eq("rst.irq", {63'd0, irq}, 64'd0);
        check_eq("rst.rvalid", {63'd0, bus.rvalid_o}, 64'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rst.irq_after", {63'd0, irq}, 64'd0);
        rd_chk("rst.cmp_hi", 3'd3, 32'hFFFF_FFFF);
        rd_chk("rst.cmp_lo", 3'd2, 32'hFFFF_FFFF);
        rd_chk("rst.ctrl", 3'd5, 32'h0);
        rd_chk("rst.period", 3'd4, 32'h0);

        // One-shot at 0x100
        csr_time = 64'hF0;
        wr(3'd2, 32'h100);
        wr(3'd3, 32'h0);
        wr(3'd5, 32'h1);
        ramp(64'hF0, 64, hit_t);
        check_eq("oneshot.hit_time", hit_t, 64'h100);
        csr_time = 64'h101;
        tick();
        tick();
        check_eq("oneshot.irq_held", {63'd0, irq}, 64'd1);
        rd_chk("oneshot.ctrl", 3'd5, 32'h4);
        wr(3'd5, 32'h4);
        check_eq("oneshot.irq_cleared", {63'd0, irq}, 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("oneshot.irq_stays_low", {63'd0, irq}, 64'd0);

        // Periodic: 0x200, +0x40
        csr_time = 64'h1F0;
        wr(3'd2, 32'h200);
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h40);
        wr(3'd5, 32'h3);
        hit_t = 64'h1EF;
        for (int k = 0; k < 3; k++) begin
            exp_hit = 64'h200 + 64'(k) * 64'h40;
            ramp(hit_t + 64'd1, 128, hit_t);
            check_eq($sformatf("periodic.hit%0d", k), hit_t, exp_hit);
            wr(3'd5, 32'h7);
            check_eq($sformatf("periodic.clr%0d", k), {63'd0, irq}, 64'd0);
            if (hit_t == '1) hit_t = exp_hit;
        end
        rd_chk("periodic.cmp_lo", 3'd2, 32'h2C0);
        wr(3'd5, 32'h0);

        // Atomic compare commit
        csr_time = 64'h1_0000_0000;
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd5, 32'h1);
        wr(3'd2, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        check_eq("atomic.lo_only_no_irq", {63'd0, irq}, 64'd0);
        wr(3'd3, 32'h2);
        check_eq("atomic.commit_no_irq", {63'd0, irq}, 64'd0);
        csr_time = 64'h1_FFFF_FFFE;
        tick();
        check_eq("atomic.before_m2", {63'd0, irq}, 64'd0);
        csr_time = 64'h1_FFFF_FFFF;
        tick();
        check_eq("atomic.before_m1", {63'd0, irq}, 64'd0);
        csr_time = 64'h2_0000_0000;
        tick();
        check_eq("atomic.at_cmp", {63'd0, irq}, 64'd1);
        rd_chk("atomic.ctrl", 3'd5, 32'h4);
        wr(3'd5, 32'h4);

        // Tear-free time read across the 32-bit carry
        csr_time = 64'h0000_0001_FFFF_FFFF;
        rd_chk("time.lo", 3'd0, 32'hFFFF_FFFF);
        csr_time = 64'h2_0000_0005;
        tick();
        rd_chk("time.hi_shadow", 3'd1, 32'h1);

        // Hit and W1C in the same cycle: set wins
        wr(3'd5, 32'h1);
        wr(3'd5, 32'h5);
        check_eq("sim.hit_w1c", {63'd0, irq}, 64'd1);
        tick();
        rd_chk("sim.hit_w1c_ctrl", 3'd5, 32'h4);
        wr(3'd5, 32'h4);
        check_eq("sim.cleared", {63'd0, irq}, 64'd0);

        // CMP_HI write coinciding with a hit, new cmp in the future
        wr(3'd2, 32'h0);
        wr(3'd5, 32'h1);
        wr(3'd3, 32'h3);
        check_eq("sim.cmphi_blocks", {63'd0, irq}, 64'd0);
        for (int i = 0; i < 3; i++) tick();
        check_eq("sim.cmphi_later", {63'd0, irq}, 64'd0);
        rd_chk("sim.cmphi_ctrl", 3'd5, 32'h1);
        wr(3'd5, 32'h0);

        // Periodic with PERIOD=0 keeps re-asserting
        wr(3'd4, 32'h0);
        csr_time = 64'h3_0000_0000;
        wr(3'd5, 32'h3);
        tick();
        check_eq("p0.first", {63'd0, irq}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            wr(3'd5, 32'h7);
            check_eq($sformatf("p0.clr%0d", i), {63'd0, irq}, 64'd1);
        end
        rd_chk("p0.cmp_hi", 3'd3, 32'h3);
        rd_chk("p0.cmp_lo", 3'd2, 32'h0);

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1 check_eq("arst.irq_now", {63'd0, irq}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("arst.irq_after", {63'd0, irq}, 64'd0);
        rd_chk("arst.cmp_hi", 3'd3, 32'hFFFF_FFFF);
        rd_chk("arst.shadow", 3'd1, 32'h0);
        rd_chk("arst.ctrl", 3'd5, 32'h0);

        // Read and write of the same register in one cycle returns the old value
        bus.we_i    = 1'b1;
        bus.re_i    = 1'b1;
        bus.addr_i  = 3'd4;
        bus.wdata_i = 32'h55;
        tick();
        bus.we_i = 1'b0;
        bus.re_i = 1'b0;
        check_eq("rw.old_value", {32'd0, bus.rdata_o}, 64'h0);
        rd_chk("rw.new_value", 3'd4, 32'h55);
        rd_chk("unmapped.6", 3'd6, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/urv_timer_irq.md
# urv_timer_irq

Timer-compare and interrupt unit that consumes the 64-bit free-running `csr_time` count produced by the core timer. Software programs a 64-bit compare value over a small 32-bit register port. The block raises a level interrupt when time reaches that value, either once or periodically with automatic reload. It also provides a tear-free 64-bit time read through 32-bit accesses, and sits between the core timer and the interrupt input of the core.

## Interface

Parameters:
- `g_reset_cmp`, default 64'hFFFF_FFFF_FFFF_FFFF: compare value after reset (never matches).

Ports:
- `clk_i`, input, 1: single clock; all logic is rising-edge.
- `rst_n_i`, input, 1: asynchronous, active-low reset.
- `csr_time_i`, input, 64: current time count from the core timer; synchronous to `clk_i`.
- `addr_i`, input, 3: word index.
- `wdata_i`, input, 32: write data.
- `we_i`, input, 1: write strobe; takes effect at this edge.
- `re_i`, input, 1: read strobe.
- `rdata_o`, output, 32: read data, registered.
- `rvalid_o`, output, 1: high for one cycle when `rdata_o` is valid.
- `irq_o`, output, 1: level interrupt; equals the pending bit.

## Operation

Register map, by word index:
- **0 TIME_LO** (RO): returns `csr_time_i[31:0]`. The same edge latches `csr_time_i[63:32]` into `time_hi_shadow`.
- **1 TIME_HI** (RO): returns `time_hi_shadow`. The pair 0 then 1 is atomic.
- **2 CMP_LO** (RW):
  - Write: loads `cmp_lo_stage` only; the active compare value is unchanged.
  - Read: returns the active `cmp[31:0]`.
- **3 CMP_HI** (RW):
  - Write: commits `cmp <= {wdata_i, cmp_lo_stage}` atomically and clears pending.
  - Read: returns `cmp[63:32]`.
- **4 PERIOD** (RW): 32-bit reload increment, zero-extended to 64 bits.
- **5 CTRL** (RW):
  - bit0 `enable`.
  - bit1 `periodic`.
  - bit2 `pending`: reads the status; writing 1 clears it (W1C).
  - Other bits read 0.
- **6, 7**: reads return 0; writes are ignored.

State machine, where state is the `enable` bit:
- **IDLE** (`enable`=0): no compare; pending holds its value. Writing CTRL with bit0=1 moves to ARMED.
- **ARMED**: each cycle evaluates `hit = (csr_time_i >= cmp)`, as an unsigned 64-bit compare.
  - hit with `periodic`=1: pending is set, `cmp <= cmp + PERIOD` (mod 2^64), and the block stays ARMED.
  - hit with `periodic`=0: pending is set, `enable` is cleared, and the block goes to IDLE (one-shot).
  - Writing CTRL with bit0=0 returns to IDLE.

Boundary rules:
- Bus write and hit in the same cycle:
  - A write to CMP_HI, PERIOD or CTRL wins: the hit is discarded for that cycle and re-evaluated next cycle with the new values.
  - A write to CMP_LO does not block the hit.
- W1C clear and hit in the same cycle: the set wins, so pending stays 1.
- Periodic mode with PERIOD=0: `cmp` does not advance. Pending re-asserts every cycle while time >= cmp, so a clear has no lasting effect.
- Periodic reload wraps modulo 2^64. If the wrapped `cmp` is below time, the block hits again on the next cycle.
- A late arm (cmp already in the past) fires on the first ARMED cycle.
- Asserting `rst_n_i` mid-operation immediately returns every register to its reset value and forces `irq_o` low.

Reset values:
- `cmp` = `g_reset_cmp`.
- `cmp_lo_stage`, `PERIOD`, CTRL, pending, `time_hi_shadow`: 0.
- `rdata_o`, `rvalid_o`, `irq_o`: 0.

## Timing

- Write latency: the register updates at the edge where `we_i`=1 and is visible to the compare on the next cycle.
- Read latency: `re_i` at edge N puts `rdata_o` and `rvalid_o` valid during cycle N+1. Back-to-back reads are allowed every cycle, and there are no stalls.
- `we_i` and `re_i` in the same cycle to the same address: the read returns the old value.
- Compare latency: if `csr_time_i >= cmp` is presented in cycle N while ARMED, `irq_o` is high from cycle N+1.
- After a periodic hit in cycle N, the new `cmp` is used for the compare in cycle N+1.
- A W1C clear at edge N drops `irq_o` in cycle N+1, unless the same cycle also had a hit.

## Test plan

- **Reset values:** hold `rst_n_i` low while toggling all inputs, then release. Required: `irq_o`=0; reading CMP_HI/CMP_LO returns FFFF_FFFF/FFFF_FFFF; reading CTRL returns 0.
- **One-shot:** write CMP_LO=0x100 and CMP_HI=0, then CTRL=1, and ramp time from 0xF0. Required:
  - `irq_o` rises exactly one cycle after time=0x100.
  - CTRL reads 0x4 (enable cleared, pending set).
  - A W1C of 0x4 drops `irq_o` and it stays low.
- **Periodic:** cmp=0x200, PERIOD=0x40, CTRL=3. Required:
  - Hits at time 0x200, 0x240 and 0x280, each followed by a clear.
  - Reading CMP_LO after the third hit returns 0x2C0.
- **Atomic compare:** with the block ARMED, time=0x1_0000_0000 and cmp high, write CMP_LO=0 and wait 10 cycles. Required: no irq, because cmp is not yet committed. Then write CMP_HI=2; required: no irq until time reaches 0x2_0000_0000.
- **Tear-free time read:** time=0x0000_0001_FFFF_FFFF; read TIME_LO, advance time past the 32-bit carry, then read TIME_HI. Required: FFFF_FFFF then 0000_0001.
- **Simultaneous events:**
  - Hit and W1C in the same cycle: pending stays 1.
  - CMP_HI write and hit in the same cycle: no irq if the new cmp is in the future.
  - PERIOD=0 in periodic mode with time ≥ cmp: `irq_o` stays high through repeated clears.
